// File: rtl/chip_tester_pkg.sv
// Shared types and constants for the chip tester result display.
//   disp_state_t : display FSM states (IDLE, ARM, SHOW, RELEASE)
//   SEG_P/SEG_F/SEG_BLANK : active-low 7-seg patterns, bit order {g..a}
//   verdict_seg() : maps a pass/fail verdict to its digit pattern
package chip_tester_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    SHOW    = 2'd2,
    RELEASE = 2'd3
  } disp_state_t;

  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] verdict_seg(input logic pass);
    return pass ? SEG_P : SEG_F;
  endfunction

endpackage

// File: rtl/chip_result_display_hold_timer.sv
// hold_timer: loadable down-counter that sets the display hold time.
// Ports:
//   clk   : clock, posedge
//   reset : synchronous active-high reset (count -> 0)
//   load  : load HOLD_CYCLES-1 (wins over en)
//   en    : decrement by one while nonzero
//   zero  : count == 0
module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int W           = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  // Loading H-1 gives H cycles of SHOW: values H-1 .. 0.
  localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                   count <= '0;
    else if (load)               count <= LOAD_VAL;
    else if (en && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/chip_result_display.sv
// chip_result_display: captures the Done/RSLT verdict from a chip tester,
// shows it on LEDs and a 7-seg digit for HOLD_CYCLES cycles (or until
// Continue), then raises DISP_RSLT until the tester drops Done.
// Optional pass/fail tallies are built when CHIP_RESULT_TALLY_EN is defined;
// otherwise PassCnt/FailCnt are tied to 0.
// Ports:
//   Clk, Reset         : clock (posedge), synchronous active-high reset
//   Done, RSLT         : tester handshake; RSLT sampled on the 2nd Done cycle
//   Continue           : user acknowledge, ends the display hold early
//   DISP_RSLT          : release back to the tester
//   LED_PASS, LED_FAIL : verdict LEDs
//   HEX0               : active-low 7-seg digit {g..a}
//   Busy               : FSM not in IDLE
//   PassCnt, FailCnt   : saturating verdict tallies
module chip_result_display
  import chip_tester_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Done,
  input  logic             RSLT,
  input  logic             Continue,
  output logic             DISP_RSLT,
  output logic             LED_PASS,
  output logic             LED_FAIL,
  output logic [6:0]       HEX0,
  output logic             Busy,
  output logic [CNT_W-1:0] PassCnt,
  output logic [CNT_W-1:0] FailCnt
);

  disp_state_t state, next_state;
  logic        verdict, next_verdict;
  logic        capture;
  logic        show_next;
  logic        tmr_zero;

  // Done must be seen on two consecutive cycles before RSLT is trusted;
  // a single-cycle Done drops back to IDLE without latching anything.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE:    if (Done) next_state = ARM;
      ARM:     if (Done) begin
                 next_state = SHOW;
                 capture    = 1'b1;
               end else begin
                 next_state = IDLE;
               end
      // Done is deliberately ignored here; the tester cannot cut the display.
      SHOW:    if (tmr_zero || Continue) next_state = RELEASE;
      // Only Done low rearms capture, so one test yields one verdict.
      RELEASE: if (!Done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .W           ($clog2(HOLD_CYCLES + 1))
  ) u_hold_timer (
    .clk   (Clk),
    .reset (Reset),
    .load  (capture),
    .en    (state == SHOW),
    .zero  (tmr_zero)
  );

  assign next_verdict = capture ? RSLT : verdict;
  // Display stays up through RELEASE and blanks on the IDLE cycle.
  assign show_next    = (next_state == SHOW) || (next_state == RELEASE);

  // Outputs are registered from the next-state values so they line up
  // with the state they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      verdict   <= 1'b0;
      DISP_RSLT <= 1'b0;
      LED_PASS  <= 1'b0;
      LED_FAIL  <= 1'b0;
      HEX0      <= SEG_BLANK;
      Busy      <= 1'b0;
    end else begin
      state     <= next_state;
      verdict   <= next_verdict;
      DISP_RSLT <= (next_state == RELEASE);
      LED_PASS  <= show_next &&  next_verdict;
      LED_FAIL  <= show_next && !next_verdict;
      HEX0      <= show_next ? verdict_seg(next_verdict) : SEG_BLANK;
      Busy      <= (next_state != IDLE);
    end
  end

`ifdef CHIP_RESULT_TALLY_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PassCnt <= '0;
      FailCnt <= '0;
    end else if (capture) begin
      if (RSLT && PassCnt != CNT_MAX)  PassCnt <= PassCnt + 1'b1;
      if (!RSLT && FailCnt != CNT_MAX) FailCnt <= FailCnt + 1'b1;
    end
  end
`else
  assign PassCnt = '0;
  assign FailCnt = '0;
`endif

endmodule
